// File: rtl/gtp_link_pkg.sv
// Shared link-layer definitions for the GTP frame transmitter and receiver:
// K-codes, EOF status values, FSM state codes and CRC-16-CCITT constants.
package gtp_link_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K28_0 = 8'h1C;  // fill
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame

  localparam logic [7:0] EOF_OK    = 8'h00;
  localparam logic [7:0] EOF_TRUNC = 8'h01;
  localparam logic [7:0] EOF_ABORT = 8'h02;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_DATA = 3'd1;
  localparam state_t ST_CRC  = 3'd2;
  localparam state_t ST_EOF  = 3'd3;
  localparam state_t ST_DROP = 3'd4;
  localparam state_t ST_GAP  = 3'd5;

  typedef struct packed {
    logic        k;
    logic [15:0] data;
  } tx_word_t;

  function automatic tx_word_t k_word(input logic [7:0] hi, input logic [7:0] code);
    return '{k: 1'b1, data: {hi, code}};
  endfunction

endpackage

// File: rtl/crc16_ccitt_w16.sv
// Combinational next-state of CRC-16-CCITT (poly 0x1021) for one 16-bit word,
// processed MSB first.
module crc16_ccitt_w16
  import gtp_link_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] d,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // NOTE: blocking '=' is correct here: each bit step must see the previous
  // step's result within the same evaluation, and c is fully assigned first.
  always_comb begin
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else              c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/gtp_frame_tx.sv
// Per-lane frame transmitter: wraps a valid/ready payload stream into
// SOF / payload / CRC / EOF frames with comma idles for one GTP TX lane.
module gtp_frame_tx
  import gtp_link_pkg::*;
#(
  parameter int MAX_WORDS = 512,
  parameter int IDLE_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up,
  input  logic [15:0] s_data,
  input  logic [7:0]  s_tag,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] tx_data,
  output logic        tx_charisk,
  output logic [15:0] frames_sent,
  output logic        trunc_err
);

  localparam logic [7:0]  GAP_LOAD = 8'(IDLE_GAP);
  localparam logic [15:0] LAST_IDX = 16'(MAX_WORDS - 1);
  localparam state_t      GAP_EXIT = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;

  state_t      state;
  tx_word_t    tx_q;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [15:0] word_cnt;
  logic [7:0]  status;
  logic [7:0]  gap_cnt;
  logic        drop;
  logic        accept;

  // Ready depends only on state and link, so upstream may gate valid on it.
  assign s_ready = link_up && (state == ST_DATA || state == ST_DROP);
  assign accept  = s_valid && s_ready;

  assign tx_data    = tx_q.data;
  assign tx_charisk = tx_q.k;

  crc16_ccitt_w16 u_crc (
    .crc_in  (crc),
    .d       (s_data),
    .crc_out (crc_next)
  );

  // NOTE: every register, datapath included, is reset so the lane drives a
  // clean comma stream straight out of reset; sequential state uses '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_q        <= k_word(8'h00, K28_5);
      crc         <= CRC_INIT;
      word_cnt    <= '0;
      status      <= EOF_OK;
      gap_cnt     <= '0;
      drop        <= 1'b0;
      frames_sent <= '0;
      trunc_err   <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_q <= k_word(8'h00, K28_5);
          if (link_up && s_valid && gap_cnt == 8'd0) begin
            tx_q     <= k_word(s_tag, K27_7);
            crc      <= CRC_INIT;
            word_cnt <= '0;
            status   <= EOF_OK;
            drop     <= 1'b0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!link_up) begin
            // Lost link mid-payload: close the frame at once, no CRC word.
            tx_q        <= k_word(EOF_ABORT, K29_7);
            frames_sent <= frames_sent + 16'd1;
            trunc_err   <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            drop        <= 1'b1;
            state       <= ST_DROP;
          end else if (s_valid) begin
            tx_q     <= '{k: 1'b0, data: s_data};
            crc      <= crc_next;
            word_cnt <= word_cnt + 16'd1;
            if (s_last) begin
              state <= ST_CRC;
            end else if (word_cnt == LAST_IDX) begin
              status <= EOF_TRUNC;
              drop   <= 1'b1;
              state  <= ST_CRC;
            end
          end else begin
            tx_q <= k_word(8'h00, K28_0);
          end
        end
        ST_CRC: begin
          tx_q  <= '{k: 1'b0, data: crc};
          state <= ST_EOF;
        end
        ST_EOF: begin
          tx_q        <= k_word(status, K29_7);
          frames_sent <= frames_sent + 16'd1;
          trunc_err   <= (status != EOF_OK);
          gap_cnt     <= GAP_LOAD;
          state       <= drop ? ST_DROP : GAP_EXIT;
        end
        ST_DROP: begin
          tx_q <= k_word(8'h00, K28_5);
          if (accept && s_last) state <= GAP_EXIT;
        end
        ST_GAP: begin
          tx_q <= k_word(8'h00, K28_5);
          if (link_up) begin
            if (gap_cnt <= 8'd1) begin
              gap_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end
        end
        default: begin
          tx_q  <= k_word(8'h00, K28_5);
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtp_frame_tx.sv
// Self-checking bench for gtp_frame_tx: directed framing cases plus random
// frames compared against a frame-level reference model.
module tb_gtp_frame_tx;

  localparam int MAXW = 4;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b1;
  logic [15:0] s_data = '0;
  logic [7:0]  s_tag = '0;
  logic        s_last = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] tx_data;
  logic        tx_charisk;
  logic [15:0] frames_sent;
  logic        trunc_err;

  // Second instance: IDLE_GAP=0, permanently fed with one-word frames.
  logic        b_ready;
  logic [15:0] b_data;
  logic        b_k;
  logic [15:0] b_frames;
  logic        b_trunc;

  always #5 clk = ~clk;

  gtp_frame_tx #(.MAX_WORDS(MAXW), .IDLE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .link_up(link_up),
    .s_data(s_data), .s_tag(s_tag), .s_last(s_last), .s_valid(s_valid),
    .s_ready(s_ready), .tx_data(tx_data), .tx_charisk(tx_charisk),
    .frames_sent(frames_sent), .trunc_err(trunc_err)
  );

  gtp_frame_tx #(.MAX_WORDS(512), .IDLE_GAP(0)) dut_b2b (
    .clk(clk), .rst_n(rst_n), .link_up(1'b1),
    .s_data(16'h0000), .s_tag(8'hC3), .s_last(1'b1), .s_valid(1'b1),
    .s_ready(b_ready), .tx_data(b_data), .tx_charisk(b_k),
    .frames_sent(b_frames), .trunc_err(b_trunc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observed line words {k, data}, sampled on the falling edge.
  bit          rec = 1'b0;
  logic [16:0] raw_q[$];
  logic [16:0] b_q[$];
  logic [16:0] exp_q[$];
  int          trunc_seen = 0;

  always @(negedge clk) begin
    if (rec) begin
      raw_q.push_back({tx_charisk, tx_data});
      b_q.push_back({b_k, b_data});
      if (trunc_err) trunc_seen++;
    end
  end

  // Reference CRC, byte-oriented MSB-first formulation.
  function automatic logic [15:0] crc_ref(input logic [15:0] w[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (w[i]) begin
      for (int b = 1; b >= 0; b--) begin
        c = c ^ {w[i][8*b +: 8], 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  // Frame-level model: what a receiver sees once idles and fills are removed.
  task automatic expect_frame(input logic [7:0] tag, input logic [15:0] w[$]);
    logic [15:0] kept[$];
    for (int i = 0; i < w.size() && i < MAXW; i++) kept.push_back(w[i]);
    exp_q.push_back({1'b1, tag, 8'hFB});
    foreach (kept[i]) exp_q.push_back({1'b0, kept[i]});
    exp_q.push_back({1'b0, crc_ref(kept)});
    exp_q.push_back({1'b1, (w.size() > MAXW) ? 8'h01 : 8'h00, 8'hFD});
  endtask

  task automatic drive_word(input logic [15:0] d, input logic [7:0] t, input logic l);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      s_data = d; s_tag = t; s_last = l; s_valid = 1'b1;
      #4;
      acc = s_ready;
      @(posedge clk);
      n++;
    end
    #1 s_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [15:0] w[$],
                            input int stall_at, input int stall_n);
    foreach (w[i]) begin
      drive_word(w[i], t, logic'(i == w.size() - 1));
      if (i == stall_at) repeat (stall_n) @(posedge clk);
    end
  endtask

  // Exact line sequence starting at the first SOF seen in raw_q.
  task automatic check_seq(input string tag, input logic [16:0] e[$]);
    int s;
    logic [16:0] got;
    s = -1;
    foreach (raw_q[i]) if (s < 0 && raw_q[i][16] && raw_q[i][7:0] == 8'hFB) s = i;
    if (s < 0) s = raw_q.size();
    foreach (e[i]) begin
      got = (s + i < raw_q.size()) ? raw_q[s + i] : 17'hx;
      check($sformatf("%s[%0d]", tag, i), 32'(got), 32'(e[i]));
    end
  endtask

  task automatic check_stream(input string tag);
    logic [16:0] f[$];
    foreach (raw_q[i])
      if (!(raw_q[i][16] && (raw_q[i][7:0] == 8'hBC || raw_q[i][7:0] == 8'h1C)))
        f.push_back(raw_q[i]);
    check({tag, "_len"}, 32'(f.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i >= f.size()) break;
      check($sformatf("%s[%0d]", tag, i), 32'(f[i]), 32'(exp_q[i]));
      if (f[i] !== exp_q[i]) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w[$];
    logic [16:0] e[$];
    logic [7:0]  tag;
    int          len, n_tr, min_gap, run, eof_i;
    logic [15:0] f0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h00BC);
    check("rst_charisk", 32'(tx_charisk), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_trunc", 32'(trunc_err), 32'd0);
    rst_n = 1'b1;
    rec = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tx_data", 32'({tx_charisk, tx_data}), 32'h1_00BC);

    // Single word, tag 5A
    @(posedge clk);
    raw_q.delete(); trunc_seen = 0;
    w = '{16'h0000};
    send_frame(8'h5A, w, -1, 0);
    repeat (8) @(posedge clk);
    e = '{17'h1_5AFB, 17'h0_0000, 17'h0_1D0F, 17'h1_00FD, 17'h1_00BC, 17'h1_00BC};
    check_seq("single", e);
    check("single_frames", 32'(frames_sent), 32'd1);
    check("single_trunc", 32'(trunc_seen), 32'd0);

    // Four words with a two-cycle stall after the second
    raw_q.delete();
    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    send_frame(8'hA3, w, 1, 2);
    repeat (8) @(posedge clk);
    e = '{{1'b1, 8'hA3, 8'hFB}, 17'h0_1111, 17'h0_2222, 17'h1_001C, 17'h1_001C,
          17'h0_3333, 17'h0_4444, {1'b0, crc_ref(w)}, 17'h1_00FD, 17'h1_00BC, 17'h1_00BC};
    check_seq("fill", e);
    check("fill_frames", 32'(frames_sent), 32'd2);

    // Truncation: six words into a four-word frame limit
    raw_q.delete(); trunc_seen = 0;
    w.delete();
    for (int i = 0; i < 6; i++) w.push_back(16'($urandom));
    send_frame(8'h77, w, -1, 0);
    repeat (8) @(posedge clk);
    e = '{{1'b1, 8'h77, 8'hFB}, {1'b0, w[0]}, {1'b0, w[1]}, {1'b0, w[2]}, {1'b0, w[3]},
          {1'b0, crc_ref(w[0:3])}, 17'h1_01FD, 17'h1_00BC, 17'h1_00BC};
    check_seq("trunc", e);
    check("trunc_pulse", 32'(trunc_seen), 32'd1);
    check("trunc_frames", 32'(frames_sent), 32'd3);

    // Link lost after the second payload word
    raw_q.delete(); trunc_seen = 0;
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
    drive_word(w[0], 8'h3C, 1'b0);
    drive_word(w[1], 8'h3C, 1'b0);
    @(negedge clk) link_up = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_hold_ready", 32'(s_ready), 32'd0);
    link_up = 1'b1;
    drive_word(w[2], 8'h3C, 1'b0);
    drive_word(w[3], 8'h3C, 1'b0);
    drive_word(w[4], 8'h3C, 1'b1);
    repeat (6) @(posedge clk);
    e = '{{1'b1, 8'h3C, 8'hFB}, {1'b0, w[0]}, {1'b0, w[1]}, 17'h1_02FD, 17'h1_00BC};
    check_seq("abort", e);
    check("abort_pulse", 32'(trunc_seen), 32'd1);
    check("abort_frames", 32'(frames_sent), 32'd4);

    // Link down while idle: no SOF, no ready
    @(negedge clk);
    link_up = 1'b0; s_valid = 1'b1; s_tag = 8'h99;
    repeat (4) @(negedge clk);
    check("linkdown_idle_tx", 32'({tx_charisk, tx_data}), 32'h1_00BC);
    check("linkdown_idle_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    link_up = 1'b1;
    check("linkdown_frames", 32'(frames_sent), 32'd4);

    // Random frames against the frame-level model
    @(posedge clk);
    raw_q.delete(); exp_q.delete(); trunc_seen = 0; n_tr = 0;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      tag = 8'($urandom);
      w.delete();
      for (int i = 0; i < len; i++) w.push_back(16'($urandom));
      expect_frame(tag, w);
      if (len > MAXW) n_tr++;
      send_frame(tag, w, int'($urandom_range(0, len)) - 1, $urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    check_stream("rand");
    check("rand_trunc", 32'(trunc_seen), 32'(n_tr));
    check("rand_frames", 32'(frames_sent), 32'd34);
    min_gap = 1000; run = -1;
    foreach (raw_q[i]) begin
      if (raw_q[i][16] && raw_q[i][7:0] == 8'hFD) run = 0;
      else if (run >= 0 && raw_q[i][16] && raw_q[i][7:0] == 8'hBC) run++;
      else if (run >= 0 && raw_q[i][16] && raw_q[i][7:0] == 8'hFB) begin
        if (run < min_gap) min_gap = run;
        run = -1;
      end
    end
    check("rand_min_gap_ok", 32'(min_gap >= GAP), 32'd1);

    // IDLE_GAP=0 instance: SOF right after EOF, one frame every 4 words
    @(negedge clk);
    f0 = b_frames;
    repeat (40) @(negedge clk);
    check("b2b_rate", 32'(16'(b_frames - f0)), 32'd10);
    eof_i = -1;
    foreach (b_q[i]) if (eof_i < 0 && i > 0 && b_q[i] == 17'h1_00FD) eof_i = i;
    if (eof_i < 0) eof_i = b_q.size() - 1;
    check("b2b_crc", 32'(b_q[eof_i - 1]), 32'h0_1D0F);
    check("b2b_sof", 32'(b_q[eof_i + 1]), 32'h1_C3FB);

    // Reset asserted mid-frame
    drive_word(16'hABCD, 8'h11, 1'b0);
    drive_word(16'h1234, 8'h11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'({tx_charisk, tx_data}), 32'h1_00BC);
    check("midrst_ready", 32'(s_ready), 32'd0);
    check("midrst_frames", 32'(frames_sent), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_tx", 32'({tx_charisk, tx_data}), 32'h1_00BC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
